pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Decides each cycle whether the PC, IF/ID and ID/EX registers advance, hold or get a bubble, and redirects the PC on jumps/branches resolved in EX.
- Handles three stall sources: load-use hazards detected against the ID stage, multi-cycle mul/div operations in EX, and bus wait.
- Also counts stall cycles and flags a hung multi-cycle unit.

Parameters:
- FLUSH_CYCLES, 1, extra cycles IF/ID is flushed after a redirect (covers ROM fetch latency); legal 0..7.
- MD_TIMEOUT, 64, maximum cycles in MD_WAIT before a forced abort; legal 2..255.
- CNT_WIDTH, 32, width of stall_count.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- id_rs1_addr  in  5  rs1 field of the instruction in ID.
- id_rs2_addr  in  5  rs2 field of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_is_load  in  1  EX instruction is a load.
- ex_we  in  1  EX instruction writes a general register.
- ex_rd_addr  in  5  EX destination register.
- ex_jump  in  1  EX resolved a taken branch/jump this cycle.
- ex_jump_addr  in  32  redirect target.
- ex_md_start  in  1  EX issued a multi-cycle mul/div this cycle.
- ex_md_done  in  1  multi-cycle unit result valid.
- bus_hold  in  1  memory bus not ready; freeze the pipeline.
- hold_pc  out  1  PC keeps its value.
- hold_if_id  out  1  IF/ID keeps its value.
- hold_id_ex  out  1  ID/EX keeps its value.
- flush_if_id  out  1  IF/ID loads a NOP.
- bubble_id_ex  out  1  ID/EX loads a NOP.
- pc_set  out  1  PC loads pc_set_addr.
- pc_set_addr  out  32  redirect target.
- md_timeout  out  1  sticky; MD_TIMEOUT expired.
- stall_count  out  CNT_WIDTH  cycles with hold_pc=1; wraps.

Behaviour:
- Reset (rst=0):
  - State=RUN; flush and timeout counters 0; md_timeout=0; stall_count=0.
  - All control outputs are forced 0; pc_set_addr=0.
- Control outputs are combinational from the state register plus inputs, i.e. they act in the same cycle. State and counters update on posedge clk.
- States:
  - RUN: normal advance.
  - FLUSH: post-redirect flush of IF/ID.
  - MD_WAIT: multi-cycle unit busy.
- Priority, highest first, evaluated each cycle: bus_hold > MD_WAIT > jump > load-use.
- bus_hold=1:
  - hold_pc, hold_if_id and hold_id_ex are all 1; every other control output is 0.
  - The FLUSH counter does not advance.
  - MD_WAIT still samples ex_md_done and the timeout counter.
  - A jump in this cycle is ignored; EX is frozen, so it re-presents next cycle.
- MD_WAIT:
  - hold_pc, hold_if_id and hold_id_ex are 1; ex_jump is ignored.
  - ex_md_done=1: the holds drop in that same cycle and the state goes to RUN.
  - Timeout counter increments each cycle. When it reaches MD_TIMEOUT, set md_timeout, drop the holds and go to RUN.
- RUN with ex_jump=1:
  - pc_set=1, pc_set_addr=ex_jump_addr, flush_if_id=1, bubble_id_ex=1.
  - ex_md_start in the same cycle is ignored.
  - If FLUSH_CYCLES>0, go to FLUSH with counter=FLUSH_CYCLES.
- FLUSH:
  - flush_if_id=1 each cycle; the counter decrements.
  - Return to RUN after the cycle in which the counter reaches 1.
  - A new ex_jump here restarts the redirect exactly as in RUN.
- RUN with ex_md_start=1 and no jump: enter MD_WAIT next cycle with the timeout counter cleared. No hold in the start cycle.
- Load-use (RUN or FLUSH, no higher-priority event):
  - Condition: ex_is_load, ex_we, ex_rd_addr!=0, and ((id_uses_rs1 and id_rs1_addr==ex_rd_addr) or (id_uses_rs2 and id_rs2_addr==ex_rd_addr)).
  - Response: hold_pc=1, hold_if_id=1, bubble_id_ex=1 for one cycle. The bubble clears the condition on the next cycle.
- stall_count: increments on every posedge where hold_pc=1 and rst=1; wraps modulo 2^CNT_WIDTH.
- md_timeout: cleared only by reset.
- Asynchronous reset mid-MD_WAIT or mid-FLUSH: returns to RUN immediately; no pending redirect survives.

Decomposition:
- Shared package (Define.v): WordWidth, GeneralRegAddrWidth, the three state encodings, and the zero-register constant.
- One sub-module, pipe_hazard_detect: purely combinational load-use compare. It is instantiated once so the same logic can later be reused for a second issue slot.

Test Plan:
- Load-use: EX load with ex_rd_addr=5, ID uses rs2=5 -> one cycle of hold_pc=1, hold_if_id=1, bubble_id_ex=1; next cycle all 0; stall_count=1. Repeat with rd=0 -> no stall.
- Jump with FLUSH_CYCLES=1: ex_jump=1, addr=0x0000_0100 -> pc_set=1 with addr 0x100, flush and bubble in the same cycle; flush_if_id=1 exactly one more cycle; then RUN.
- Mul/div: ex_md_start, then ex_md_done asserted 10 cycles later -> holds for 10 cycles, released in the done cycle; stall_count=10.
- Timeout: MD_TIMEOUT=8 with done never asserted -> md_timeout=1 after 8 cycles, holds drop, md_timeout stays 1 until reset.
- Simultaneous events:
  - bus_hold together with ex_jump -> no pc_set; jump applied in the first cycle after bus_hold drops.
  - ex_jump together with ex_md_start -> jump taken, no MD_WAIT.
- Reset mid-MD_WAIT: drive rst=0 asynchronously -> all outputs 0 immediately; after release, state RUN and stall_count=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencing controller and its hazard
// detector: data and register-address widths, the controller state encoding
// and the hard-wired zero register number.
package pipe_ctrl_pkg;

  localparam int WordWidth           = 32;
  localparam int GeneralRegAddrWidth = 5;

  // x0 always reads as zero, so a write to it can never create a hazard.
  localparam logic [GeneralRegAddrWidth-1:0] ZeroReg = '0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MD_WAIT = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect
// Purely combinational load-use hazard compare between the instruction in ID
// and a load sitting in EX.
// Ports:
//   i_id_rs1_addr / i_id_rs2_addr  source register fields of the ID instruction
//   i_id_uses_rs1 / i_id_uses_rs2  ID instruction actually reads that source
//   i_ex_is_load                   EX instruction is a load
//   i_ex_we                        EX instruction writes a general register
//   i_ex_rd_addr                   EX destination register
//   o_load_use                     ID must wait one cycle for the load data
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [GeneralRegAddrWidth-1:0] i_id_rs1_addr,
  input  logic [GeneralRegAddrWidth-1:0] i_id_rs2_addr,
  input  logic                           i_id_uses_rs1,
  input  logic                           i_id_uses_rs2,
  input  logic                           i_ex_is_load,
  input  logic                           i_ex_we,
  input  logic [GeneralRegAddrWidth-1:0] i_ex_rd_addr,
  output logic                           o_load_use
);

  logic w_rs1_match;
  logic w_rs2_match;
  logic w_load_writes;

  assign w_rs1_match   = i_id_uses_rs1 && (i_id_rs1_addr == i_ex_rd_addr);
  assign w_rs2_match   = i_id_uses_rs2 && (i_id_rs2_addr == i_ex_rd_addr);
  assign w_load_writes = i_ex_is_load && i_ex_we && (i_ex_rd_addr != ZeroReg);
  assign o_load_use    = w_load_writes && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Pipeline sequencing controller for the 5-stage core. Each cycle it decides
// whether PC, IF/ID and ID/EX advance, hold or take a bubble, redirects the PC
// on jumps resolved in EX, counts stall cycles and flags a hung mul/div unit.
// Ports:
//   clk, rst (async, active-low)
//   id_*           source register usage of the instruction in ID
//   ex_*           load/writeback, jump and mul/div status of the EX stage
//   bus_hold       memory bus not ready, freeze everything
//   hold_*         stage register keeps its value
//   flush_if_id    IF/ID loads a NOP
//   bubble_id_ex   ID/EX loads a NOP
//   pc_set, pc_set_addr  PC redirect
//   md_timeout     sticky, mul/div unit never answered
//   stall_count    number of cycles with hold_pc=1 (wraps)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MD_TIMEOUT   = 64,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [GeneralRegAddrWidth-1:0] id_rs1_addr,
  input  logic [GeneralRegAddrWidth-1:0] id_rs2_addr,
  input  logic                           id_uses_rs1,
  input  logic                           id_uses_rs2,
  input  logic                           ex_is_load,
  input  logic                           ex_we,
  input  logic [GeneralRegAddrWidth-1:0] ex_rd_addr,
  input  logic                           ex_jump,
  input  logic [WordWidth-1:0]           ex_jump_addr,
  input  logic                           ex_md_start,
  input  logic                           ex_md_done,
  input  logic                           bus_hold,
  output logic                           hold_pc,
  output logic                           hold_if_id,
  output logic                           hold_id_ex,
  output logic                           flush_if_id,
  output logic                           bubble_id_ex,
  output logic                           pc_set,
  output logic [WordWidth-1:0]           pc_set_addr,
  output logic                           md_timeout,
  output logic [CNT_WIDTH-1:0]           stall_count
);

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES);
  // The last MD_WAIT cycle that still holds; at its end the counter has
  // reached MD_TIMEOUT and the wait is abandoned.
  localparam logic [7:0] TmoLast   = 8'(MD_TIMEOUT - 1);

  pipe_state_t          r_state;
  pipe_state_t          w_next_state;
  logic [2:0]           r_flush_cnt;
  logic [2:0]           w_next_flush;
  logic [7:0]           r_tmo_cnt;
  logic [7:0]           w_next_tmo;
  logic                 r_md_timeout;
  logic                 w_set_timeout;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic                 w_load_use;

  logic                 w_hold_pc;
  logic                 w_hold_if_id;
  logic                 w_hold_id_ex;
  logic                 w_flush_if_id;
  logic                 w_bubble_id_ex;
  logic                 w_pc_set;
  logic [WordWidth-1:0] w_pc_set_addr;

  pipe_hazard_detect u_hazard (
    .i_id_rs1_addr (id_rs1_addr),
    .i_id_rs2_addr (id_rs2_addr),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_is_load  (ex_is_load),
    .i_ex_we       (ex_we),
    .i_ex_rd_addr  (ex_rd_addr),
    .o_load_use    (w_load_use)
  );

  always_comb begin
    w_next_state   = r_state;
    w_next_flush   = r_flush_cnt;
    w_next_tmo     = r_tmo_cnt;
    w_set_timeout  = 1'b0;
    w_hold_pc      = 1'b0;
    w_hold_if_id   = 1'b0;
    w_hold_id_ex   = 1'b0;
    w_flush_if_id  = 1'b0;
    w_bubble_id_ex = 1'b0;
    w_pc_set       = 1'b0;
    w_pc_set_addr  = '0;

    // The mul/div unit keeps running while the bus is frozen, so its
    // completion and timeout are tracked independently of bus_hold.
    if (r_state == ST_MD_WAIT) begin
      if (ex_md_done) begin
        w_next_state = ST_RUN;
      end else begin
        w_next_tmo = r_tmo_cnt + 8'd1;
        if (r_tmo_cnt >= TmoLast) begin
          w_set_timeout = 1'b1;
          w_next_state  = ST_RUN;
        end
      end
    end

    if (bus_hold) begin
      // Whole pipe frozen; a jump in EX stays there and is seen again later.
      w_hold_pc    = 1'b1;
      w_hold_if_id = 1'b1;
      w_hold_id_ex = 1'b1;
    end else begin
      case (r_state)
        ST_MD_WAIT: begin
          w_hold_pc    = !ex_md_done;
          w_hold_if_id = !ex_md_done;
          w_hold_id_ex = !ex_md_done;
        end
        ST_RUN, ST_FLUSH: begin
          if (ex_jump) begin
            w_pc_set       = 1'b1;
            w_pc_set_addr  = ex_jump_addr;
            w_flush_if_id  = 1'b1;
            w_bubble_id_ex = 1'b1;
            w_next_flush   = FlushInit;
            w_next_state   = (FLUSH_CYCLES != 0) ? ST_FLUSH : ST_RUN;
          end else begin
            if (r_state == ST_FLUSH) begin
              w_flush_if_id = 1'b1;
              w_next_flush  = r_flush_cnt - 3'd1;
              if (r_flush_cnt <= 3'd1) begin
                w_next_state = ST_RUN;
              end
            end else if (ex_md_start) begin
              w_next_state = ST_MD_WAIT;
              w_next_tmo   = 8'd0;
            end
            if (w_load_use) begin
              w_hold_pc      = 1'b1;
              w_hold_if_id   = 1'b1;
              w_bubble_id_ex = 1'b1;
            end
          end
        end
        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  // Outputs are forced quiet while reset is asserted so nothing downstream
  // reacts to a half-reset pipeline.
  assign hold_pc      = rst & w_hold_pc;
  assign hold_if_id   = rst & w_hold_if_id;
  assign hold_id_ex   = rst & w_hold_id_ex;
  assign flush_if_id  = rst & w_flush_if_id;
  assign bubble_id_ex = rst & w_bubble_id_ex;
  assign pc_set       = rst & w_pc_set;
  assign pc_set_addr  = rst ? w_pc_set_addr : '0;
  assign md_timeout   = r_md_timeout;
  assign stall_count  = r_stall_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_flush_cnt   <= 3'd0;
      r_tmo_cnt     <= 8'd0;
      r_md_timeout  <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_next_flush;
      r_tmo_cnt   <= w_next_tmo;
      if (w_set_timeout) begin
        r_md_timeout <= 1'b1;
      end
      if (w_hold_pc) begin
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Directed bench for pipe_ctrl. Inputs change on the falling edge and the
// combinational controls are sampled 1ns later, well away from the rising
// edge. A second instance with MD_TIMEOUT=8 covers the mul/div timeout.
module tb_pipe_ctrl;

  localparam logic [5:0] CtrlIdle    = 6'b000000;
  localparam logic [5:0] CtrlLoadUse = 6'b110010;
  localparam logic [5:0] CtrlJump    = 6'b000111;
  localparam logic [5:0] CtrlFlush   = 6'b000100;
  localparam logic [5:0] CtrlFreeze  = 6'b111000;

  logic        clk;
  logic        rst;
  logic [4:0]  idRs1Addr;
  logic [4:0]  idRs2Addr;
  logic        idUsesRs1;
  logic        idUsesRs2;
  logic        exIsLoad;
  logic        exWe;
  logic [4:0]  exRdAddr;
  logic        exJump;
  logic [31:0] exJumpAddr;
  logic        exMdStart;
  logic        exMdDone;
  logic        busHold;

  logic        holdPc, holdIfId, holdIdEx, flushIfId, bubbleIdEx, pcSet;
  logic [31:0] pcSetAddr;
  logic        mdTimeout;
  logic [31:0] stallCount;

  logic        holdPcTo, holdIfIdTo, holdIdExTo, flushIfIdTo, bubbleIdExTo, pcSetTo;
  logic [31:0] pcSetAddrTo;
  logic        mdTimeoutTo;
  logic [31:0] stallCountTo;

  // Control outputs packed as {hold_pc, hold_if_id, hold_id_ex,
  // flush_if_id, bubble_id_ex, pc_set}.
  logic [5:0]  ctrl;
  logic [5:0]  ctrlTo;
  assign ctrl   = {holdPc, holdIfId, holdIdEx, flushIfId, bubbleIdEx, pcSet};
  assign ctrlTo = {holdPcTo, holdIfIdTo, holdIdExTo, flushIfIdTo, bubbleIdExTo, pcSetTo};

  int assertCount;
  int failCount;

  typedef struct {
    logic       isLoad;
    logic       we;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       uses1;
    logic [4:0] rs2;
    logic       uses2;
    logic       stall;
  } luVec_t;

  luVec_t luTable[7];

  pipe_ctrl #(.FLUSH_CYCLES(1), .MD_TIMEOUT(64), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(idRs1Addr), .id_rs2_addr(idRs2Addr),
    .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2),
    .ex_is_load(exIsLoad), .ex_we(exWe), .ex_rd_addr(exRdAddr),
    .ex_jump(exJump), .ex_jump_addr(exJumpAddr),
    .ex_md_start(exMdStart), .ex_md_done(exMdDone), .bus_hold(busHold),
    .hold_pc(holdPc), .hold_if_id(holdIfId), .hold_id_ex(holdIdEx),
    .flush_if_id(flushIfId), .bubble_id_ex(bubbleIdEx),
    .pc_set(pcSet), .pc_set_addr(pcSetAddr),
    .md_timeout(mdTimeout), .stall_count(stallCount)
  );

  pipe_ctrl #(.FLUSH_CYCLES(1), .MD_TIMEOUT(8), .CNT_WIDTH(32)) dutTo (
    .clk(clk), .rst(rst),
    .id_rs1_addr(idRs1Addr), .id_rs2_addr(idRs2Addr),
    .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2),
    .ex_is_load(exIsLoad), .ex_we(exWe), .ex_rd_addr(exRdAddr),
    .ex_jump(exJump), .ex_jump_addr(exJumpAddr),
    .ex_md_start(exMdStart), .ex_md_done(exMdDone), .bus_hold(busHold),
    .hold_pc(holdPcTo), .hold_if_id(holdIfIdTo), .hold_id_ex(holdIdExTo),
    .flush_if_id(flushIfIdTo), .bubble_id_ex(bubbleIdExTo),
    .pc_set(pcSetTo), .pc_set_addr(pcSetAddrTo),
    .md_timeout(mdTimeoutTo), .stall_count(stallCountTo)
  );

  // 10ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive every data input to its quiet value.
  task automatic applyStimulus();
    idRs1Addr  = 5'd0;
    idRs2Addr  = 5'd0;
    idUsesRs1  = 1'b0;
    idUsesRs2  = 1'b0;
    exIsLoad   = 1'b0;
    exWe       = 1'b0;
    exRdAddr   = 5'd0;
    exJump     = 1'b0;
    exJumpAddr = 32'd0;
    exMdStart  = 1'b0;
    exMdDone   = 1'b0;
    busHold    = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic applyReset();
    @(negedge clk);
    applyStimulus();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  // Reset with busy inputs: every control must be forced low.
  task automatic test_reset();
    exJump     = 1'b1;
    exJumpAddr = 32'h0000_1234;
    busHold    = 1'b1;
    exIsLoad   = 1'b1;
    #2;
    assertCount++;
    if (ctrl !== CtrlIdle) begin
      failCount++;
      $display("[TB] FAIL reset_ctrl: got %b want %b", ctrl, CtrlIdle);
    end
    assertCount++;
    if (pcSetAddr !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL reset_pc_set_addr: got %h want %h", pcSetAddr, 32'd0);
    end
    assertCount++;
    if (stallCount !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL reset_stall_count: got %0d want 0", stallCount);
    end
    assertCount++;
    if (mdTimeout !== 1'b0 || mdTimeoutTo !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_md_timeout: got %b/%b want 0/0", mdTimeout, mdTimeoutTo);
    end
    @(negedge clk);
    applyStimulus();
    rst = 1'b1;
    #1;
    assertCount++;
    if (ctrl !== CtrlIdle) begin
      failCount++;
      $display("[TB] FAIL reset_release_ctrl: got %b want %b", ctrl, CtrlIdle);
    end
  endtask

  task automatic test_load_use();
    luTable[0] = '{1'b1, 1'b1, 5'd5,  5'd3,  1'b1, 5'd5,  1'b1, 1'b1};
    luTable[1] = '{1'b1, 1'b1, 5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b0};
    luTable[2] = '{1'b1, 1'b1, 5'd7,  5'd7,  1'b1, 5'd2,  1'b1, 1'b1};
    luTable[3] = '{1'b1, 1'b1, 5'd7,  5'd7,  1'b0, 5'd7,  1'b0, 1'b0};
    luTable[4] = '{1'b0, 1'b1, 5'd9,  5'd9,  1'b1, 5'd1,  1'b0, 1'b0};
    luTable[5] = '{1'b1, 1'b0, 5'd9,  5'd9,  1'b1, 5'd1,  1'b0, 1'b0};
    luTable[6] = '{1'b1, 1'b1, 5'd31, 5'd4,  1'b0, 5'd31, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      exIsLoad  = luTable[i].isLoad;
      exWe      = luTable[i].we;
      exRdAddr  = luTable[i].rd;
      idRs1Addr = luTable[i].rs1;
      idUsesRs1 = luTable[i].uses1;
      idRs2Addr = luTable[i].rs2;
      idUsesRs2 = luTable[i].uses2;
      #1;
      assertCount++;
      if (ctrl !== (luTable[i].stall ? CtrlLoadUse : CtrlIdle)) begin
        failCount++;
        $display("[TB] FAIL load_use_vec%0d: got %b want %b", i, ctrl,
                 luTable[i].stall ? CtrlLoadUse : CtrlIdle);
      end
      // The bubble has replaced the load in EX on the following cycle.
      @(negedge clk);
      applyStimulus();
      #1;
      assertCount++;
      if (ctrl !== CtrlIdle) begin
        failCount++;
        $display("[TB] FAIL load_use_after%0d: got %b want %b", i, ctrl, CtrlIdle);
      end
      if (i == 0) begin
        assertCount++;
        if (stallCount !== 32'd1) begin
          failCount++;
          $display("[TB] FAIL load_use_stall_count1: got %0d want 1", stallCount);
        end
      end
    end
    assertCount++;
    if (stallCount !== 32'd3) begin
      failCount++;
      $display("[TB] FAIL load_use_stall_count3: got %0d want 3", stallCount);
    end
  endtask

  task automatic test_jump();
    @(negedge clk);
    exJump     = 1'b1;
    exJumpAddr = 32'h0000_0100;
    #1;
    assertCount++;
    if (ctrl !== CtrlJump) begin
      failCount++;
      $display("[TB] FAIL jump_ctrl: got %b want %b", ctrl, CtrlJump);
    end
    assertCount++;
    if (pcSetAddr !== 32'h0000_0100) begin
      failCount++;
      $display("[TB] FAIL jump_addr: got %h want %h", pcSetAddr, 32'h0000_0100);
    end
    @(negedge clk);
    applyStimulus();
    #1;
    assertCount++;
    if (ctrl !== CtrlFlush) begin
      failCount++;
      $display("[TB] FAIL jump_flush: got %b want %b", ctrl, CtrlFlush);
    end
    @(negedge clk);
    #1;
    assertCount++;
    if (ctrl !== CtrlIdle) begin
      failCount++;
      $display("[TB] FAIL jump_back_to_run: got %b want %b", ctrl, CtrlIdle);
    end
  endtask

  // Jump and mul/div start together: the jump wins and no wait follows.
  task automatic test_jump_md();
    @(negedge clk);
    exJump     = 1'b1;
    exJumpAddr = 32'h0000_0200;
    exMdStart  = 1'b1;
    #1;
    assertCount++;
    if (ctrl !== CtrlJump || pcSetAddr !== 32'h0000_0200) begin
      failCount++;
      $display("[TB] FAIL jump_md_ctrl: got %b/%h want %b/%h", ctrl, pcSetAddr,
               CtrlJump, 32'h0000_0200);
    end
    @(negedge clk);
    applyStimulus();
    #1;
    assertCount++;
    if (ctrl !== CtrlFlush) begin
      failCount++;
      $display("[TB] FAIL jump_md_flush: got %b want %b", ctrl, CtrlFlush);
    end
    @(negedge clk);
    #1;
    assertCount++;
    if (ctrl !== CtrlIdle) begin
      failCount++;
      $display("[TB] FAIL jump_md_no_wait: got %b want %b", ctrl, CtrlIdle);
    end
  endtask

  // bus_hold masks a jump; the jump applies once the bus is released.
  task automatic test_bus_hold_jump();
    @(negedge clk);
    busHold    = 1'b1;
    exJump     = 1'b1;
    exJumpAddr = 32'h0000_0300;
    #1;
    assertCount++;
    if (ctrl !== CtrlFreeze) begin
      failCount++;
      $display("[TB] FAIL bus_hold_ctrl: got %b want %b", ctrl, CtrlFreeze);
    end
    @(negedge clk);
    busHold = 1'b0;
    #1;
    assertCount++;
    if (ctrl !== CtrlJump || pcSetAddr !== 32'h0000_0300) begin
      failCount++;
      $display("[TB] FAIL bus_hold_late_jump: got %b/%h want %b/%h", ctrl, pcSetAddr,
               CtrlJump, 32'h0000_0300);
    end
    @(negedge clk);
    applyStimulus();
    #1;
    assertCount++;
    if (ctrl !== CtrlFlush) begin
      failCount++;
      $display("[TB] FAIL bus_hold_flush: got %b want %b", ctrl, CtrlFlush);
    end
  endtask

  task automatic test_muldiv();
    applyReset();
    @(negedge clk);
    exMdStart = 1'b1;
    #1;
    assertCount++;
    if (ctrl !== CtrlIdle) begin
      failCount++;
      $display("[TB] FAIL md_start_no_hold: got %b want %b", ctrl, CtrlIdle);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exMdStart = 1'b0;
      #1;
      assertCount++;
      if (ctrl !== CtrlFreeze) begin
        failCount++;
        $display("[TB] FAIL md_hold%0d: got %b want %b", i, ctrl, CtrlFreeze);
      end
    end
    @(negedge clk);
    exMdDone = 1'b1;
    #1;
    assertCount++;
    if (ctrl !== CtrlIdle) begin
      failCount++;
      $display("[TB] FAIL md_done_release: got %b want %b", ctrl, CtrlIdle);
    end
    @(negedge clk);
    exMdDone = 1'b0;
    #1;
    assertCount++;
    if (ctrl !== CtrlIdle) begin
      failCount++;
      $display("[TB] FAIL md_after_done: got %b want %b", ctrl, CtrlIdle);
    end
    assertCount++;
    if (stallCount !== 32'd10 || mdTimeout !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL md_stall_count: got %0d/%b want 10/0", stallCount, mdTimeout);
    end
  endtask

  task automatic test_timeout();
    applyReset();
    @(negedge clk);
    exMdStart = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exMdStart = 1'b0;
      #1;
      assertCount++;
      if (ctrlTo !== CtrlFreeze || mdTimeoutTo !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL tmo_hold%0d: got %b/%b want %b/0", i, ctrlTo, mdTimeoutTo,
                 CtrlFreeze);
      end
    end
    @(negedge clk);
    #1;
    assertCount++;
    if (ctrlTo !== CtrlIdle || mdTimeoutTo !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL tmo_expire: got %b/%b want %b/1", ctrlTo, mdTimeoutTo, CtrlIdle);
    end
    assertCount++;
    if (stallCountTo !== 32'd8) begin
      failCount++;
      $display("[TB] FAIL tmo_stall_count: got %0d want 8", stallCountTo);
    end
    repeat (3) @(negedge clk);
    #1;
    assertCount++;
    if (mdTimeoutTo !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL tmo_sticky: got %b want 1", mdTimeoutTo);
    end
  endtask

  task automatic test_reset_mid_md();
    applyReset();
    @(negedge clk);
    exMdStart = 1'b1;
    @(negedge clk);
    exMdStart = 1'b0;
    #1;
    assertCount++;
    if (ctrl !== CtrlFreeze) begin
      failCount++;
      $display("[TB] FAIL rst_md_pre: got %b want %b", ctrl, CtrlFreeze);
    end
    #1;
    rst = 1'b0;
    #1;
    assertCount++;
    if (ctrl !== CtrlIdle || stallCount !== 32'd0 || mdTimeoutTo !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rst_md_async: got %b/%0d/%b want %b/0/0", ctrl, stallCount,
               mdTimeoutTo, CtrlIdle);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    assertCount++;
    if (ctrl !== CtrlIdle || stallCount !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL rst_md_run: got %b/%0d want %b/0", ctrl, stallCount, CtrlIdle);
    end
  endtask

  task automatic test_reset_mid_flush();
    @(negedge clk);
    exJump     = 1'b1;
    exJumpAddr = 32'h0000_0400;
    @(negedge clk);
    applyStimulus();
    #1;
    assertCount++;
    if (ctrl !== CtrlFlush) begin
      failCount++;
      $display("[TB] FAIL rst_flush_pre: got %b want %b", ctrl, CtrlFlush);
    end
    #1;
    rst = 1'b0;
    #1;
    assertCount++;
    if (ctrl !== CtrlIdle) begin
      failCount++;
      $display("[TB] FAIL rst_flush_async: got %b want %b", ctrl, CtrlIdle);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    assertCount++;
    if (ctrl !== CtrlIdle) begin
      failCount++;
      $display("[TB] FAIL rst_flush_run: got %b want %b", ctrl, CtrlIdle);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst         = 1'b0;
    applyStimulus();
    test_reset();
    test_load_use();
    test_jump();
    test_jump_md();
    test_bus_hold_jump();
    test_muldiv();
    test_timeout();
    test_reset_mid_md();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got no end of test, want finish before 50000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
